// File: rtl/calc_entry_sequencer.sv
// Calculator entry sequencer: debounces the two buttons, captures sign/operand/operator
// slot by slot, launches the arithmetic unit and supervises it with a timeout.
module calc_entry_sequencer #(
  parameter int DEB_CYC = 20,
  parameter int TIMEOUT = 255
) (
  input  logic        clk1kHz,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        btn_res,
  input  logic [3:0]  digit_in,
  input  logic [1:0]  op_in,
  input  logic        alu_done,
  input  logic        alu_err,
  output logic        alu_start,
  output logic [11:0] num1_bcd,
  output logic [11:0] num2_bcd,
  output logic        sign1,
  output logic [1:0]  op_code,
  output logic [2:0]  pos,
  output logic        show_result,
  output logic        err
);

  localparam int CW = $clog2(DEB_CYC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {ENTRY, LAUNCH, WAIT, RESULT, ERROR} state_t;

  state_t          state, next_state;
  logic [1:0]      raw, sync1, sync2, level, press;
  logic [CW-1:0]   cnt [2];
  logic [TW-1:0]   timer;
  logic            next_press, res_press, timeout_hit;
  logic            latch_en, clear_en;
  logic [3:0]      digit_sat;

  // Index 0 = next button, index 1 = res button (both active-low, so level 1 = released)
  assign raw = {btn_res, btn_next};

  always_ff @(posedge clk1kHz) begin
    if (rst) begin
      sync1  <= '1;
      sync2  <= '1;
      level  <= '1;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEB_CYC - 1)) begin
          level[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // A press is the cycle in which the DEB_CYC-th differing low sample arrives
  always_comb begin
    press = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      press[i] = level[i] && !sync2[i] && (cnt[i] == CW'(DEB_CYC - 1));
    end
  end

  assign next_press  = press[0];
  assign res_press   = press[1];
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));
  assign latch_en    = (state == ENTRY) && (next_press || res_press);
  assign clear_en    = ((state == RESULT) || (state == ERROR)) && res_press;
  assign digit_sat   = (digit_in > 4'd9) ? 4'd9 : digit_in;

  always_ff @(posedge clk1kHz) begin
    if (rst) state <= ENTRY;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ENTRY:  if (res_press || (next_press && (pos == 3'd7))) next_state = LAUNCH;
      LAUNCH: next_state = WAIT;
      WAIT: begin
        if (alu_done)         next_state = alu_err ? ERROR : RESULT;
        else if (timeout_hit) next_state = ERROR;
      end
      RESULT, ERROR: if (res_press) next_state = ENTRY;
      default: next_state = ENTRY;
    endcase
  end

  always_comb begin
    alu_start   = (state == LAUNCH);
    show_result = (state == RESULT) || (state == ERROR);
    err         = (state == ERROR);
  end

  always_ff @(posedge clk1kHz) begin
    if (rst || (state == LAUNCH)) timer <= '0;
    else if (state == WAIT)       timer <= timer + TW'(1);
  end

  always_ff @(posedge clk1kHz) begin
    if (rst || clear_en) begin
      num1_bcd <= '0;
      num2_bcd <= '0;
      sign1    <= 1'b0;
      op_code  <= '0;
      pos      <= '0;
    end else if (latch_en) begin
      case (pos)
        3'd0: sign1          <= digit_in[0];
        3'd1: num1_bcd[11:8] <= digit_sat;
        3'd2: num1_bcd[7:4]  <= digit_sat;
        3'd3: num1_bcd[3:0]  <= digit_sat;
        3'd4: op_code        <= op_in;
        3'd5: num2_bcd[11:8] <= digit_sat;
        3'd6: num2_bcd[7:4]  <= digit_sat;
        3'd7: num2_bcd[3:0]  <= digit_sat;
        default: ;
      endcase
      // res latches once and holds pos; slot 7 holds pos as well
      if (!res_press && (pos != 3'd7)) pos <= pos + 3'd1;
    end
  end

endmodule
